// File: rtl/trdb_pkg.sv
// Shared types and defaults for the trace resync controller.
//
// Contents:
//   RESYNC_CNT_W   - default width of the resync interval counter
//   resync_mode_e  - what advances the interval counter (clock cycles or packets)
//   resync_state_e - states of the resync request FSM
package trdb_pkg;

    localparam int unsigned RESYNC_CNT_W = 16;

    typedef enum logic {
        CYCLE_MODE  = 1'b0,
        PACKET_MODE = 1'b1
    } resync_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        COUNT = 2'd2,
        REQ   = 2'd3
    } resync_state_e;

endpackage

// File: rtl/trdb_resync_counter.sv
// Resync interval counter: increment with saturation, clear, and a threshold
// compare against a live limit value.
//
// Ports:
//   clk_i     - clock, rising edge
//   rst_ni    - asynchronous active-low reset, counter to 0
//   clear     - force the count to 0 next cycle (highest priority)
//   inc       - count one event this cycle
//   max_val   - threshold; 0 disables the threshold compare
//   count     - current interval count
//   at_limit  - the incremented count would reach the threshold; qualified
//               by the caller with its event, so it does not depend on inc
module trdb_resync_counter
    import trdb_pkg::*;
#(
    parameter int unsigned CNT_W = RESYNC_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] max_val,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] count_next;

    // Holds at all-ones instead of wrapping, so an unbounded interval
    // (threshold 0) reads as "very long" rather than restarting at 0.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        if (&v) begin
            return v;
        end
        return v + one;
    endfunction

    assign count_inc = sat_inc(count_q);
    assign at_limit  = (max_val != '0) && (count_inc >= max_val);

    always_comb begin
        count_next = count_q;
        if (clear) begin
            count_next = '0;
        end else if (inc) begin
            count_next = at_limit ? '0 : count_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/trdb_resync_ctrl.sv
// Trace resync controller: asks the packet emitter for a sync (full-address)
// packet when tracing starts and then periodically, every resync_max_i
// events. Events are clock cycles or emitted packets depending on the mode
// latched when tracing is enabled.
//
// Configuration:
//   TRDB_RESYNC_PKT_MODE_EN defined   - CYCLE_MODE and PACKET_MODE supported
//   TRDB_RESYNC_PKT_MODE_EN undefined - CYCLE_MODE only; resync_mode_i and
//                                       packet_emitted_i are ignored
//
// Ports:
//   clk_i            - clock, rising edge
//   rst_ni           - asynchronous active-low reset
//   trace_enabled_i  - tracer enabled; low returns the block to IDLE
//   packet_emitted_i - one-cycle pulse per emitted trace packet
//   resync_mode_i    - 0 CYCLE_MODE, 1 PACKET_MODE; latched on leaving IDLE
//   resync_max_i     - resync interval threshold, 0 = no periodic resync
//   resync_req_o     - sync packet request, held until acknowledged
//   resync_ack_i     - pulse: a sync packet was emitted (any cause)
//   count_o          - current interval count
//   overrun_o        - pulse: threshold reached again while still requesting
module trdb_resync_ctrl
    import trdb_pkg::*;
#(
    parameter int unsigned CNT_W = RESYNC_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             trace_enabled_i,
    input  logic             packet_emitted_i,
    input  logic             resync_mode_i,
    input  logic [CNT_W-1:0] resync_max_i,
    output logic             resync_req_o,
    input  logic             resync_ack_i,
    output logic [CNT_W-1:0] count_o,
    output logic             overrun_o
);

    resync_state_e state_q;
    resync_state_e state_d;

    logic cnt_event;
    logic cnt_clear;
    logic cnt_inc;
    logic cnt_at_limit;
    logic overrun_q;
    logic overrun_next;

`ifdef TRDB_RESYNC_PKT_MODE_EN
    resync_mode_e mode_q;

    // Mode is only taken when leaving IDLE so a change mid-trace cannot
    // alter the meaning of a partially accumulated interval.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= CYCLE_MODE;
        end else if ((state_q == IDLE) && trace_enabled_i) begin
            mode_q <= resync_mode_e'(resync_mode_i);
        end
    end

    assign cnt_event = (mode_q == PACKET_MODE) ? packet_emitted_i : 1'b1;
`else
    logic unused_mode_inputs;
    assign unused_mode_inputs = resync_mode_i ^ packet_emitted_i;
    assign cnt_event          = 1'b1;
`endif

    trdb_resync_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .max_val  (resync_max_i),
        .count    (count_o),
        .at_limit (cnt_at_limit)
    );

    always_comb begin
        state_d      = state_q;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;
        overrun_next = 1'b0;

        if (!trace_enabled_i) begin
            // Disable overrides everything, including a coincident ack.
            state_d   = IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_clear = 1'b1;
                    state_d   = START;
                end
                START: begin
                    cnt_clear = 1'b1;
                    state_d   = REQ;
                end
                COUNT: begin
                    // Any sync packet restarts the interval, and wins over a
                    // threshold hit in the same cycle.
                    if (resync_ack_i) begin
                        cnt_clear = 1'b1;
                    end else begin
                        cnt_inc = cnt_event;
                        if (cnt_event && cnt_at_limit) begin
                            state_d = REQ;
                        end
                    end
                end
                REQ: begin
                    if (resync_ack_i) begin
                        cnt_clear = 1'b1;
                        state_d   = COUNT;
                    end else begin
                        // Keep measuring while waiting so a slow emitter is
                        // reported once per missed interval.
                        cnt_inc      = cnt_event;
                        overrun_next = cnt_event && cnt_at_limit;
                    end
                end
                default: begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_next;
        end
    end

    // Decoded straight from the state register so reset drops it at once.
    assign resync_req_o = (state_q == START) || (state_q == REQ);
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_trdb_resync_ctrl.sv
module tb_trdb_resync_ctrl;

    logic        clk;
    logic        rst_n;
    logic        trace_en;
    logic        pkt;
    logic        mode;
    logic [15:0] max;
    logic        req;
    logic        ack;
    logic [15:0] count;
    logic        ov;

    int n_checks;
    int n_fail;

    trdb_resync_ctrl #(
        .CNT_W (16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .trace_enabled_i  (trace_en),
        .packet_emitted_i (pkt),
        .resync_mode_i    (mode),
        .resync_max_i     (max),
        .resync_req_o     (req),
        .resync_ack_i     (ack),
        .count_o          (count),
        .overrun_o        (ov)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // IDLE -> START -> REQ, then ack the initial request: ends in COUNT, count 0.
    task automatic enable_and_ack(input logic m, input logic [15:0] mx);
        mode     = m;
        max      = mx;
        trace_en = 1'b1;
        step();
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic finish_scenario();
        trace_en = 1'b0;
        ack      = 1'b0;
        pkt      = 1'b0;
        mode     = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        trace_en = 1'b1;
        step();
        step();
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
        n_checks++; if (count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0h expected 0", count); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", ov); end
        trace_en = 1'b0;
        rst_n    = 1'b1;
        step();
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b expected 0", req); end
    endtask

    task automatic test_cycle_mode();
        mode     = 1'b0;
        max      = 16'd4;
        trace_en = 1'b1;
        step();
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL cyc_start_req: got %b expected 1", req); end
        step();
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL cyc_req_held: got %b expected 1", req); end
        step();
        n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL cyc_req_count: got %0d expected 1", count); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (req !== 1'b0 || count !== 16'd0) begin n_fail++; $display("FAIL cyc_after_ack: got req=%b count=%0d expected req=0 count=0", req, count); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (req !== 1'b0 || count !== i[15:0]) begin n_fail++; $display("FAIL cyc_count_%0d: got req=%b count=%0d expected req=0 count=%0d", i, req, count, i); end
        end
        step();
        n_checks++; if (req !== 1'b1 || count !== 16'd0) begin n_fail++; $display("FAIL cyc_periodic_req: got req=%b count=%0d expected req=1 count=0", req, count); end
        finish_scenario();
    endtask

    task automatic test_packet_mode();
`ifdef TRDB_RESYNC_PKT_MODE_EN
        enable_and_ack(1'b1, 16'd3);
        mode = 1'b0;
        for (int p = 1; p <= 2; p++) begin
            pkt = 1'b1;
            step();
            pkt = 1'b0;
            n_checks++; if (count !== p[15:0] || req !== 1'b0) begin n_fail++; $display("FAIL pkt_pulse_%0d: got count=%0d req=%b expected count=%0d req=0", p, count, req, p); end
            step();
            n_checks++; if (count !== p[15:0]) begin n_fail++; $display("FAIL pkt_gap_%0d: got count=%0d expected %0d", p, count, p); end
        end
        pkt = 1'b1;
        step();
        pkt = 1'b0;
        n_checks++; if (req !== 1'b1 || count !== 16'd0) begin n_fail++; $display("FAIL pkt_req: got req=%b count=%0d expected req=1 count=0", req, count); end
`else
        enable_and_ack(1'b1, 16'd3);
        pkt = 1'b0;
        step();
        n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL nopkt_count1: got %0d expected 1", count); end
        step();
        n_checks++; if (count !== 16'd2) begin n_fail++; $display("FAIL nopkt_count2: got %0d expected 2", count); end
        step();
        n_checks++; if (req !== 1'b1 || count !== 16'd0) begin n_fail++; $display("FAIL nopkt_req: got req=%b count=%0d expected req=1 count=0", req, count); end
`endif
        finish_scenario();
    endtask

    task automatic test_overrun();
        mode     = 1'b0;
        max      = 16'd3;
        trace_en = 1'b1;
        step();
        step();
        for (int i = 1; i <= 10; i++) begin
            step();
            n_checks++;
            if (req !== 1'b1 || count !== 16'(i % 3) || ov !== ((i % 3) == 0)) begin
                n_fail++;
                $display("FAIL ovr_cycle_%0d: got req=%b count=%0d ov=%b expected req=1 count=%0d ov=%b", i, req, count, ov, i % 3, (i % 3) == 0);
            end
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (req !== 1'b0 || count !== 16'd0 || ov !== 1'b0) begin n_fail++; $display("FAIL ovr_ack: got req=%b count=%0d ov=%b expected 0 0 0", req, count, ov); end
        finish_scenario();
    endtask

    task automatic test_unsolicited_ack();
        enable_and_ack(1'b0, 16'd4);
        step();
        step();
        n_checks++; if (count !== 16'd2) begin n_fail++; $display("FAIL uack_pre: got %0d expected 2", count); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (count !== 16'd0 || req !== 1'b0) begin n_fail++; $display("FAIL uack_clear: got count=%0d req=%b expected 0 0", count, req); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (req !== 1'b0 || count !== i[15:0]) begin n_fail++; $display("FAIL uack_count_%0d: got req=%b count=%0d expected req=0 count=%0d", i, req, count, i); end
        end
        step();
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL uack_req: got %b expected 1", req); end
        // Leave REQ, then collide an ack with the threshold-hitting event.
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        step();
        step();
        n_checks++; if (count !== 16'd3) begin n_fail++; $display("FAIL race_pre: got %0d expected 3", count); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (req !== 1'b0 || count !== 16'd0) begin n_fail++; $display("FAIL race_ack_wins: got req=%b count=%0d expected 0 0", req, count); end
        step();
        n_checks++; if (req !== 1'b0 || count !== 16'd1) begin n_fail++; $display("FAIL race_stay_count: got req=%b count=%0d expected req=0 count=1", req, count); end
        finish_scenario();
    endtask

    task automatic test_disable_and_reset();
        mode     = 1'b0;
        max      = 16'd4;
        trace_en = 1'b1;
        step();
        step();
        trace_en = 1'b0;
        ack      = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (req !== 1'b0 || count !== 16'd0) begin n_fail++; $display("FAIL dis_ack: got req=%b count=%0d expected 0 0", req, count); end
        step();
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL dis_stay_idle: got %b expected 0", req); end
        trace_en = 1'b1;
        step();
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL dis_restart: got %b expected 1", req); end
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (req !== 1'b0 || count !== 16'd0) begin n_fail++; $display("FAIL async_reset: got req=%b count=%0d expected 0 0", req, count); end
        step();
        trace_en = 1'b0;
        rst_n    = 1'b1;
        step();
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL post_reset: got %b expected 0", req); end
        finish_scenario();
    endtask

    task automatic test_saturate();
        logic bad_req;
        logic bad_ov;
        bad_req = 1'b0;
        bad_ov  = 1'b0;
        enable_and_ack(1'b0, 16'd0);
        for (int i = 1; i <= 70000; i++) begin
            step();
            if (req !== 1'b0) bad_req = 1'b1;
            if (ov !== 1'b0) bad_ov = 1'b1;
            if (i == 100) begin
                n_checks++; if (count !== 16'd100) begin n_fail++; $display("FAIL sat_count_100: got %0d expected 100", count); end
            end
            if (i == 65535) begin
                n_checks++; if (count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %0h expected ffff", count); end
            end
        end
        n_checks++; if (bad_req !== 1'b0) begin n_fail++; $display("FAIL sat_no_req: got %b expected 0", bad_req); end
        n_checks++; if (bad_ov !== 1'b0) begin n_fail++; $display("FAIL sat_no_overrun: got %b expected 0", bad_ov); end
        n_checks++; if (count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %0h expected ffff", count); end
        finish_scenario();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        trace_en = 1'b0;
        pkt      = 1'b0;
        mode     = 1'b0;
        max      = 16'd0;
        ack      = 1'b0;

        test_reset();
        test_cycle_mode();
        test_packet_mode();
        test_overrun();
        test_unsolicited_ack();
        test_disable_and_reset();
        test_saturate();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trdb_resync_ctrl.md
TRDB_RESYNC_CTRL -- requirements
Module: trdb_resync_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the resync interval counter and threshold.
REQ-002 Port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port trace_enabled_i  input  1  tracer enabled; low forces the block idle.
REQ-005 Port packet_emitted_i  input  1  one-cycle pulse per emitted trace packet.
REQ-006 Port resync_mode_i  input  1  0 = CYCLE_MODE, 1 = PACKET_MODE; sampled only on enable.
REQ-007 Port resync_max_i  input  CNT_W  resync interval threshold; 0 disables periodic resync; compared live.
REQ-008 Port resync_req_o  output  1  request to the packet emitter for a sync (full-address) packet.
REQ-009 Port resync_ack_i  input  1  pulse: a sync packet was emitted, for any cause.
REQ-010 Port count_o  output  CNT_W  current interval count.
REQ-011 Port overrun_o  output  1  one-cycle pulse: threshold reached again while a request is outstanding.

Function
REQ-012 FSM states SHALL be IDLE, START, COUNT, REQ.
REQ-013 IDLE: count 0, req 0; trace_enabled_i high -> START; latch resync_mode_i.
REQ-014 START: resync_req_o high (initial sync); go to REQ the next cycle with the request held.
REQ-015 Increment event SHALL be every cycle in CYCLE_MODE and each packet_emitted_i pulse in PACKET_MODE.
REQ-016 COUNT: on event, count+1; if count+1 >= resync_max_i and resync_max_i != 0 -> REQ, count cleared to 0.
REQ-017 resync_req_o SHALL assert the cycle after the threshold-hitting event (1-cycle latency).
REQ-018 REQ: resync_req_o held high until resync_ack_i sampled high; then -> COUNT, count cleared.
REQ-019 REQ: count keeps counting; reaching threshold again SHALL pulse overrun_o, clear count, stay in REQ.
REQ-020 resync_ack_i in COUNT SHALL clear count (any sync restarts the interval); state unchanged.
REQ-021 Ack and threshold in the same COUNT cycle: ack wins, count 0, stay COUNT, no request.
REQ-022 trace_enabled_i low in any state -> IDLE next cycle, req dropped, count 0; wins over simultaneous ack.
REQ-023 Counter SHALL saturate at all-ones and never wrap, even when resync_max_i is 0.
REQ-024 resync_mode_i changes while enabled SHALL be ignored until the next IDLE exit.

Reset
REQ-025 On rst_ni low: state IDLE, count_o 0, resync_req_o 0, overrun_o 0, latched mode CYCLE_MODE.
REQ-026 Reset mid-request SHALL drop resync_req_o asynchronously; no ack is expected afterwards.

Configuration
REQ-027 Macro TRDB_RESYNC_PKT_MODE_EN defined: both modes supported per REQ-015.
REQ-028 Macro undefined: resync_mode_i and packet_emitted_i ignored; CYCLE_MODE only; ports retained.

Structure
REQ-029 trdb_pkg SHALL hold the resync mode enum (CYCLE_MODE, PACKET_MODE), the FSM state enum, and default CNT_W.
REQ-030 Counting datapath (increment, saturate, clear, threshold compare) SHALL be a sub-module trdb_resync_counter; the FSM stays in trdb_resync_ctrl.

Verification
REQ-031 Enable, CYCLE_MODE, max=4, ack 2 cycles after req -> initial req; after ack, req again 5 cycles after the ack cycle.
REQ-032 PACKET_MODE, max=3, packets every 2 cycles -> req the cycle after the 3rd pulse; idle cycles do not advance count.
REQ-033 CYCLE_MODE, max=3, ack withheld 10 cycles -> req held; overrun_o pulses every 3 cycles while waiting.
REQ-034 Unsolicited ack at count=2, max=4 -> count 0 next cycle, no req until 4 further cycles.
REQ-035 Disable during REQ with simultaneous ack -> IDLE, req 0, count 0; async reset mid-REQ -> req 0 immediately.
REQ-036 max=0, 70000 cycles -> no periodic req; count_o saturates at 0xFFFF.
